// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small byte FIFO.
//
// Sends 8N1 frames on TX, LSB first, and holds each bit for DB clock cycles.
// Queued bytes go out back-to-back with no idle gap between frames.
// DB is sampled only when a frame is loaded, so changing it mid-frame
// affects the next frame only.
//
// Optional build macro:
//   UART_TX_PARITY_EN  when defined, frames are 8E1 (11 bits). An even-parity
//                      bit goes between d7 and the stop bit.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   trmt     push request; tx_data is queued when trmt=1 and full=0
//   tx_data  byte to queue
//   DB       baud divisor in clk cycles per bit (16..8191)
//   TX       serial line, idles high, registered
//   tx_done  one-cycle pulse after a frame's stop bit completes
//   busy     high while a frame is on the line
//   full     FIFO holds DEPTH entries
//   empty    FIFO holds 0 entries
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trmt,
  input  logic [7:0]  tx_data,
  input  logic [12:0] DB,
  output logic        TX,
  output logic        tx_done,
  output logic        busy,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FrameBits = 11;
`else
  localparam int unsigned FrameBits = 10;
`endif

  localparam logic [0:0]     IDLE    = 1'b0;
  localparam logic [0:0]     XMIT    = 1'b1;
  localparam logic [PTR_W:0] FullCnt = (PTR_W+1)'(DEPTH);
  localparam logic [3:0]     LastBit = 4'(FrameBits - 1);

  logic [7:0]           mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       count_q, count_d;
  logic [0:0]           state_q, state_d;
  logic [FrameBits-1:0] shift_q, shift_d;
  logic [12:0]          db_q, db_d;
  logic [12:0]          baud_cnt_q, baud_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 tx_done_q, tx_done_d;

  logic                 push, pop, baud_tick, frame_end;
  logic [7:0]           head;
  logic [FrameBits-1:0] frame;

  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);
  // Uses the registered full flag, so a push while full is dropped even if
  // a pop frees a slot in the same cycle.
  assign push  = trmt & ~full;
  assign head  = mem_q[rd_ptr_q];

  assign baud_tick = (baud_cnt_q == db_q - 13'd1);
  // Last cycle of the stop (or final) bit.
  assign frame_end = (state_q == XMIT) & baud_tick & (bit_cnt_q == LastBit);
  assign pop       = ~empty & ((state_q == IDLE) | frame_end);

`ifdef UART_TX_PARITY_EN
  assign frame = {1'b1, ^head, head, 1'b0};
`else
  assign frame = {1'b1, head, 1'b0};
`endif

  assign TX      = shift_q[0];
  assign tx_done = tx_done_q;
  assign busy    = (state_q == XMIT);

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    db_d       = db_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d    = XMIT;
          shift_d    = frame;
          db_d       = DB;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      XMIT: begin
        if (baud_tick) begin
          // Shift in ones so the line idles high once the frame is out.
          shift_d    = {1'b1, shift_q[FrameBits-1:1]};
          baud_cnt_d = '0;
          bit_cnt_d  = bit_cnt_q + 4'd1;
        end else begin
          baud_cnt_d = baud_cnt_q + 13'd1;
        end
        if (frame_end) begin
          tx_done_d = 1'b1;
          if (pop) begin
            // Reload on the same edge: the next start bit follows with no gap.
            shift_d    = frame;
            db_d       = DB;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '1;
      db_q       <= 13'd16;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      db_q       <= db_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_done_q  <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
// Stimulus pushes {byte, divisor} expectations into a queue; a line monitor
// decodes frames from TX, pops the queue and compares data, bit timing and
// tx_done placement. Build with UART_TX_PARITY_EN to exercise 8E1 frames.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct {
    logic [7:0] data;
    int         db;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        trmt;
  logic [7:0]  tx_data;
  logic [12:0] DB;
  logic        TX;
  logic        tx_done;
  logic        busy;
  logic        full;
  logic        empty;

  int              checks;
  int              errors;
  int              done_cnt;
  logic            mon_busy;
  logic [NB-1:0]   last_rx;
  exp_t            exp_q[$];

  uart_tx_fifo #(.DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .DB      (DB),
    .TX      (TX),
    .tx_done (tx_done),
    .busy    (busy),
    .full    (full),
    .empty   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NB-1:0] exp_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic exp_push(input logic [7:0] d, input int db);
    exp_t e;
    e.data = d;
    e.db   = db;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size() == 0 && !mon_busy), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Line monitor: sample index t counts negedges from the first low sample
  // of the start bit; bit i is sampled at i*db + db/2.
  initial begin : monitor
    int            t;
    exp_t          cur;
    logic [NB-1:0] rx;
    logic          bad_done;
    mon_busy = 1'b0;
    done_cnt = 0;
    t        = 0;
    rx       = '0;
    bad_done = 1'b0;
    cur.data = 8'h00;
    cur.db   = 16;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_busy = 1'b0;
        continue;
      end
      if (tx_done === 1'b1) done_cnt++;
      if (mon_busy) begin
        t++;
        if (t == NB * cur.db) begin
          checks++;
          if (tx_done !== 1'b1 || bad_done) begin
            errors++;
            $display("FAIL done_timing: data %0h tx_done %b early %b, expected pulse at cycle %0d",
                     cur.data, tx_done, bad_done, NB * cur.db);
          end
          checks++;
          if (rx !== exp_frame(cur.data)) begin
            errors++;
            $display("FAIL frame: got %0h, expected %0h", rx, exp_frame(cur.data));
          end
          last_rx  = rx;
          mon_busy = 1'b0;
        end else begin
          if (tx_done !== 1'b0) bad_done = 1'b1;
          if (t % cur.db == cur.db / 2) rx[t / cur.db] = TX;
        end
      end
      if (!mon_busy && TX === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got start bit, expected idle line");
          cur.data = 8'h00;
          cur.db   = int'(DB);
        end else begin
          cur = exp_q.pop_front();
        end
        t        = 0;
        rx       = '0;
        rx[0]    = TX;
        bad_done = 1'b0;
        mon_busy = 1'b1;
      end
    end
  end

  initial begin : main
    int d0;
    int busy_cyc;
    logic seen;
    logic [7:0] bytes3 [3];
    logic [7:0] bytes6 [6];
    checks  = 0;
    errors  = 0;
    last_rx = '0;
    rst_n   = 1'b0;
    trmt    = 1'b0;
    tx_data = 8'h00;
    DB      = 13'd16;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(TX), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    rst_n = 1'b1;

    // Single frame 8'hA5: latency and bit pattern
    @(negedge clk);
    d0 = done_cnt;
    trmt = 1'b1;
    tx_data = 8'hA5;
    exp_push(8'hA5, 16);
    @(posedge clk); #1;
    check("lat_tx_edge_k", 32'(TX), 32'd1);
    check("lat_empty_edge_k", 32'(empty), 32'd0);
    @(negedge clk);
    trmt = 1'b0;
    @(posedge clk); #1;
    check("lat_tx_edge_k1", 32'(TX), 32'd0);
    check("lat_busy_edge_k1", 32'(busy), 32'd1);
    check("lat_empty_edge_k1", 32'(empty), 32'd1);
    wait_drain(400, "a5_drain");
    check("a5_done_cnt", 32'(done_cnt - d0), 32'd1);
`ifdef UART_TX_PARITY_EN
    check("a5_bits", 32'(last_rx), 32'h54A);
`else
    check("a5_bits", 32'(last_rx), 32'h34A);
`endif

    // Three back-to-back frames; busy must stay high for all of them
    bytes3[0] = 8'h00;
    bytes3[1] = 8'hFF;
    bytes3[2] = 8'h3C;
    d0 = done_cnt;
    busy_cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (busy) seen = 1'b1;
      if (i < 3) begin
        trmt = 1'b1;
        tx_data = bytes3[i];
        exp_push(bytes3[i], 16);
      end else begin
        trmt = 1'b0;
      end
    end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy) begin
        busy_cyc++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    wait_drain(200, "b2b_drain");
    check("b2b_busy_cycles", 32'(busy_cyc), 32'(NB * 16 * 3));
    check("b2b_done_cnt", 32'(done_cnt - d0), 32'd3);

    // Overfill: five pushes fill the line plus FIFO, the sixth is dropped
    bytes6[0] = 8'h11;
    bytes6[1] = 8'h22;
    bytes6[2] = 8'h33;
    bytes6[3] = 8'h44;
    bytes6[4] = 8'h55;
    bytes6[5] = 8'h66;
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 5) check("ovf_full_after_5", 32'(full), 32'd1);
      trmt = 1'b1;
      tx_data = bytes6[i];
      if (i < 5) exp_push(bytes6[i], 16);
    end
    @(negedge clk);
    trmt = 1'b0;
    check("ovf_full_after_6", 32'(full), 32'd1);
    wait_drain(6 * NB * 16 + 100, "ovf_drain");
    check("ovf_done_cnt", 32'(done_cnt - d0), 32'd5);
    check("ovf_empty_end", 32'(empty), 32'd1);

    // Divisor change mid-frame applies from the next frame on
    d0 = done_cnt;
    @(negedge clk);
    trmt = 1'b1;
    tx_data = 8'h5A;
    exp_push(8'h5A, 16);
    @(negedge clk);
    tx_data = 8'hC3;
    exp_push(8'hC3, 32);
    @(negedge clk);
    trmt = 1'b0;
    repeat (50) @(negedge clk);
    DB = 13'd32;
    wait_drain(NB * 48 + 100, "db_drain");
    check("db_done_cnt", 32'(done_cnt - d0), 32'd2);
    DB = 13'd16;

`ifdef UART_TX_PARITY_EN
    // Even parity: 8'h07 carries parity 1, 8'h03 carries parity 0
    @(negedge clk);
    trmt = 1'b1;
    tx_data = 8'h07;
    exp_push(8'h07, 16);
    @(negedge clk);
    trmt = 1'b0;
    wait_drain(300, "par07_drain");
    check("par07_bits", 32'(last_rx), 32'h60E);
    @(negedge clk);
    trmt = 1'b1;
    tx_data = 8'h03;
    exp_push(8'h03, 16);
    @(negedge clk);
    trmt = 1'b0;
    wait_drain(300, "par03_drain");
    check("par03_bits", 32'(last_rx), 32'h406);
`endif

    // Reset mid-frame aborts the frame and discards queued bytes
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      trmt = 1'b1;
      tx_data = 8'h81 + 8'(i);
      exp_push(8'h81 + 8'(i), 16);
    end
    @(negedge clk);
    trmt = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_tx", 32'(TX), 32'd1);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (200) @(negedge clk);
    check("post_rst_tx", 32'(TX), 32'd1);
    check("post_rst_done_cnt", 32'(done_cnt - d0), 32'd0);
    check("post_rst_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
